// File: rtl/tri_setup.sv
// Triangle setup: captures three vertices, then time-shares one multiplier to build
// edge coefficients, twice-area and bounding box, and hands the result downstream.
module tri_setup #(
  parameter bit CULL_BACK = 1'b1
) (
  input  logic               clk_pix,
  input  logic               resetn,
  input  logic               start,
  input  logic [8:0]         ax,
  input  logic [8:0]         ay,
  input  logic [8:0]         bx,
  input  logic [8:0]         by,
  input  logic [8:0]         cx,
  input  logic [8:0]         cy,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [9:0]  e0_a,
  output logic signed [9:0]  e0_b,
  output logic signed [9:0]  e1_a,
  output logic signed [9:0]  e1_b,
  output logic signed [9:0]  e2_a,
  output logic signed [9:0]  e2_b,
  output logic signed [19:0] e0_c,
  output logic signed [19:0] e1_c,
  output logic signed [19:0] e2_c,
  output logic signed [20:0] area2,
  output logic [8:0]         min_x,
  output logic [8:0]         min_y,
  output logic [8:0]         max_x,
  output logic [8:0]         max_y,
  output logic               culled
);

  localparam int unsigned CW  = 9;
  localparam int unsigned AW  = 10;
  localparam int unsigned CCW = 20;
  localparam int unsigned ARW = 21;
  localparam int unsigned PW  = 19;
  localparam logic [2:0]  LAST_STEP = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, AREA, OUT} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          step;
  logic [CW-1:0]       xa, ya, xb, yb, xc, yc;
  logic [CW-1:0]       mul_x, mul_y;
  logic [PW-1:0]       prod;
  logic signed [ARW-1:0] area_sum;
  logic                drop;

  function automatic logic [CW-1:0] min3(input logic [CW-1:0] p, input logic [CW-1:0] q,
                                          input logic [CW-1:0] r);
    logic [CW-1:0] m;
    m = (p < q) ? p : q;
    return (m < r) ? m : r;
  endfunction

  function automatic logic [CW-1:0] max3(input logic [CW-1:0] p, input logic [CW-1:0] q,
                                          input logic [CW-1:0] r);
    logic [CW-1:0] m;
    m = (p > q) ? p : q;
    return (m > r) ? m : r;
  endfunction

  // Shared multiplier operand schedule: even steps form the positive term of C, odd the negative
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (step)
      3'd0: begin mul_x = xa; mul_y = yb; end
      3'd1: begin mul_x = xb; mul_y = ya; end
      3'd2: begin mul_x = xb; mul_y = yc; end
      3'd3: begin mul_x = xc; mul_y = yb; end
      3'd4: begin mul_x = xc; mul_y = ya; end
      3'd5: begin mul_x = xa; mul_y = yc; end
      default: ;
    endcase
    prod = PW'(mul_x) * PW'(mul_y);
  end

  assign area_sum = ARW'(e0_c) + ARW'(e1_c) + ARW'(e2_c);
  assign drop     = (area_sum == '0) || (CULL_BACK && (area_sum > 0));

  always_ff @(posedge clk_pix) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL;
      MUL:     if (step == LAST_STEP) state_nxt = AREA;
      AREA:    state_nxt = drop ? IDLE : OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (!resetn) begin
      busy <= 1'b0; out_valid <= 1'b0; culled <= 1'b0; step <= '0;
      xa <= '0; ya <= '0; xb <= '0; yb <= '0; xc <= '0; yc <= '0;
      e0_a <= '0; e0_b <= '0; e1_a <= '0; e1_b <= '0; e2_a <= '0; e2_b <= '0;
      e0_c <= '0; e1_c <= '0; e2_c <= '0; area2 <= '0;
      min_x <= '0; min_y <= '0; max_x <= '0; max_y <= '0;
    end else begin
      busy      <= (state_nxt != IDLE);
      out_valid <= (state_nxt == OUT);
      culled    <= (state == AREA) && drop;
      if (state == IDLE && start) begin
        xa <= ax; ya <= ay; xb <= bx; yb <= by; xc <= cx; yc <= cy;
        step <= '0;
      end
      if (state == MUL) begin
        step <= step + 3'd1;
        case (step)
          3'd0: begin
            e0_c <= CCW'(prod);
            e0_a <= AW'(ya) - AW'(yb); e0_b <= AW'(xb) - AW'(xa);
            e1_a <= AW'(yb) - AW'(yc); e1_b <= AW'(xc) - AW'(xb);
            e2_a <= AW'(yc) - AW'(ya); e2_b <= AW'(xa) - AW'(xc);
            min_x <= min3(xa, xb, xc); max_x <= max3(xa, xb, xc);
            min_y <= min3(ya, yb, yc); max_y <= max3(ya, yb, yc);
          end
          3'd1: e0_c <= e0_c - CCW'(prod);
          3'd2: e1_c <= CCW'(prod);
          3'd3: e1_c <= e1_c - CCW'(prod);
          3'd4: e2_c <= CCW'(prod);
          3'd5: e2_c <= e2_c - CCW'(prod);
          default: ;
        endcase
      end
      if (state == AREA) area2 <= area_sum;
    end
  end

endmodule

// File: tb/tb_tri_setup.sv
// Randomized bench for tri_setup: two instances (culling on/off) against an integer
// reference model of the edge equations, area and bounding box.
module tb_tri_setup;

  logic clk_pix, resetn, start, out_ready;
  logic [8:0] ax, ay, bx, by, cx, cy;

  logic busy, out_valid, culled;
  logic signed [9:0]  e0_a, e0_b, e1_a, e1_b, e2_a, e2_b;
  logic signed [19:0] e0_c, e1_c, e2_c;
  logic signed [20:0] area2;
  logic [8:0] min_x, min_y, max_x, max_y;

  logic n_busy, n_out_valid, n_culled;
  logic signed [9:0]  n_e0_a, n_e0_b, n_e1_a, n_e1_b, n_e2_a, n_e2_b;
  logic signed [19:0] n_e0_c, n_e1_c, n_e2_c;
  logic signed [20:0] n_area2;
  logic [8:0] n_min_x, n_min_y, n_max_x, n_max_y;

  int n_checks = 0;
  int n_pass   = 0;

  int ea[3], eb[3], ec[3];
  int exp_area, exp_mnx, exp_mny, exp_mxx, exp_mxy;

  tri_setup #(.CULL_BACK(1'b1)) dut (
    .clk_pix(clk_pix), .resetn(resetn), .start(start),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .e0_a(e0_a), .e0_b(e0_b), .e1_a(e1_a), .e1_b(e1_b), .e2_a(e2_a), .e2_b(e2_b),
    .e0_c(e0_c), .e1_c(e1_c), .e2_c(e2_c), .area2(area2),
    .min_x(min_x), .min_y(min_y), .max_x(max_x), .max_y(max_y), .culled(culled));

  tri_setup #(.CULL_BACK(1'b0)) dut_nc (
    .clk_pix(clk_pix), .resetn(resetn), .start(start),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .busy(n_busy), .out_valid(n_out_valid), .out_ready(out_ready),
    .e0_a(n_e0_a), .e0_b(n_e0_b), .e1_a(n_e1_a), .e1_b(n_e1_b), .e2_a(n_e2_a), .e2_b(n_e2_b),
    .e0_c(n_e0_c), .e1_c(n_e1_c), .e2_c(n_e2_c), .area2(n_area2),
    .min_x(n_min_x), .min_y(n_min_y), .max_x(n_max_x), .max_y(n_max_y), .culled(n_culled));

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Edge function from (x0,y0) to (x1,y1)
  task automatic edge_fn(input int x0, input int y0, input int x1, input int y1,
                         output int a, output int b, output int c);
    a = y0 - y1;
    b = x1 - x0;
    c = x0 * y1 - x1 * y0;
  endtask

  task automatic model(input int xa, input int ya, input int xb, input int yb,
                       input int xc, input int yc);
    edge_fn(xa, ya, xb, yb, ea[0], eb[0], ec[0]);
    edge_fn(xb, yb, xc, yc, ea[1], eb[1], ec[1]);
    edge_fn(xc, yc, xa, ya, ea[2], eb[2], ec[2]);
    exp_area = ec[0] + ec[1] + ec[2];
    exp_mnx = (xa < xb ? xa : xb); exp_mnx = (exp_mnx < xc ? exp_mnx : xc);
    exp_mxx = (xa > xb ? xa : xb); exp_mxx = (exp_mxx > xc ? exp_mxx : xc);
    exp_mny = (ya < yb ? ya : yb); exp_mny = (exp_mny < yc ? exp_mny : yc);
    exp_mxy = (ya > yb ? ya : yb); exp_mxy = (exp_mxy > yc ? exp_mxy : yc);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".e0_a"}, e0_a, ea[0]); check({tag, ".e0_b"}, e0_b, eb[0]);
    check({tag, ".e0_c"}, e0_c, ec[0]);
    check({tag, ".e1_a"}, e1_a, ea[1]); check({tag, ".e1_b"}, e1_b, eb[1]);
    check({tag, ".e1_c"}, e1_c, ec[1]);
    check({tag, ".e2_a"}, e2_a, ea[2]); check({tag, ".e2_b"}, e2_b, eb[2]);
    check({tag, ".e2_c"}, e2_c, ec[2]);
    check({tag, ".area2"}, area2, exp_area);
    check({tag, ".min_x"}, min_x, exp_mnx); check({tag, ".min_y"}, min_y, exp_mny);
    check({tag, ".max_x"}, max_x, exp_mxx); check({tag, ".max_y"}, max_y, exp_mxy);
  endtask

  task automatic scramble_inputs();
    ax = 9'($urandom); ay = 9'($urandom); bx = 9'($urandom);
    by = 9'($urandom); cx = 9'($urandom); cy = 9'($urandom);
  endtask

  // Start in the cycle after a negedge; cycle k counts clock periods after the capture edge.
  task automatic run_tri(input string tag, input int xa, input int ya, input int xb,
                         input int yb, input int xc, input int yc, input int hold,
                         input bit poke);
    bit emit_c, emit_n;
    model(xa, ya, xb, yb, xc, yc);
    emit_c = exp_area < 0;
    emit_n = exp_area != 0;
    out_ready = 1'b0;
    ax = 9'(xa); ay = 9'(ya); bx = 9'(xb); by = 9'(yb); cx = 9'(xc); cy = 9'(yc);
    start = 1'b1;
    @(posedge clk_pix);
    @(negedge clk_pix);
    start = 1'b0;
    scramble_inputs();
    for (int k = 1; k < 8; k++) begin
      if (k == 7) begin
        check({tag, ".busy_k7"}, busy, 1);
        check({tag, ".valid_k7"}, out_valid, 0);
        check({tag, ".n_valid_k7"}, n_out_valid, 0);
      end
      @(negedge clk_pix);
    end
    check({tag, ".valid"}, out_valid, emit_c);
    check({tag, ".culled"}, culled, !emit_c);
    check({tag, ".n_valid"}, n_out_valid, emit_n);
    check({tag, ".n_culled"}, n_culled, !emit_n);
    if (emit_c) check_outputs(tag);
    else        check({tag, ".busy_cull"}, busy, 0);
    if (emit_n) begin
      check({tag, ".n_area2"}, n_area2, exp_area);
      check({tag, ".n_e1_c"}, n_e1_c, ec[1]);
    end
    if (!emit_c && !emit_n) begin
      @(negedge clk_pix);
      check({tag, ".culled_once"}, culled, 0);
      check({tag, ".n_culled_once"}, n_culled, 0);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 1 && emit_c) begin
        start = 1'b1;
        scramble_inputs();
      end
      @(negedge clk_pix);
      start = 1'b0;
      if (emit_c) begin
        check({tag, ".hold_valid"}, out_valid, 1);
        check({tag, ".hold_e0_c"}, e0_c, ec[0]);
        check({tag, ".hold_area2"}, area2, exp_area);
        check({tag, ".hold_max_x"}, max_x, exp_mxx);
      end
      if (emit_n) check({tag, ".n_hold_area2"}, n_area2, exp_area);
    end
    out_ready = 1'b1;
    @(negedge clk_pix);
    out_ready = 1'b0;
    check({tag, ".done_busy"}, busy, 0);
    check({tag, ".done_valid"}, out_valid, 0);
    check({tag, ".n_done_busy"}, n_busy, 0);
    check({tag, ".n_done_valid"}, n_out_valid, 0);
    check({tag, ".done_culled"}, culled, 0);
  endtask

  initial begin
    int v[6];
    clk_pix = 1'b0; resetn = 1'b0; start = 1'b0; out_ready = 1'b0;
    ax = '0; ay = '0; bx = '0; by = '0; cx = '0; cy = '0;
    repeat (3) @(negedge clk_pix);
    check("rst.busy", busy, 0);
    check("rst.valid", out_valid, 0);
    check("rst.culled", culled, 0);
    check("rst.area2", area2, 0);
    check("rst.e0_c", e0_c, 0);
    check("rst.min_x", min_x, 0);
    check("rst.n_busy", n_busy, 0);
    resetn = 1'b1;
    @(negedge clk_pix);

    run_tri("front", 320, 120, 240, 240, 400, 240, 0, 1'b0);
    check("front.e0_a_lit", e0_a, -120);
    check("front.e0_b_lit", e0_b, -80);
    check("front.e0_c_lit", e0_c, 48000);
    check("front.area_lit", area2, -19200);
    run_tri("back", 320, 120, 400, 240, 240, 240, 0, 1'b0);
    check("back.n_area_lit", n_area2, 19200);
    run_tri("degen", 10, 10, 20, 20, 30, 30, 0, 1'b0);
    run_tri("bp", 320, 120, 240, 240, 400, 240, 20, 1'b1);
    run_tri("corner", 511, 0, 0, 511, 511, 511, 2, 1'b0);

    // Reset in the middle of the multiply sequence, then a clean run
    ax = 9'd320; ay = 9'd120; bx = 9'd240; by = 9'd240; cx = 9'd400; cy = 9'd240;
    start = 1'b1;
    @(posedge clk_pix);
    @(negedge clk_pix);
    start = 1'b0;
    repeat (2) @(negedge clk_pix);
    resetn = 1'b0;
    @(negedge clk_pix);
    check("midrst.busy", busy, 0);
    check("midrst.valid", out_valid, 0);
    check("midrst.n_busy", n_busy, 0);
    resetn = 1'b1;
    @(negedge clk_pix);
    run_tri("postrst", 100, 50, 30, 200, 250, 180, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      foreach (v[j]) v[j] = int'($urandom_range(511, 0));
      if ($urandom_range(4, 0) == 0) begin
        v[4] = v[0]; v[5] = v[1];
      end
      run_tri($sformatf("rnd%0d", i), v[0], v[1], v[2], v[3], v[4], v[5],
              int'($urandom_range(3, 0)), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
